// File: rtl/sqrt_sum_fsm.sv
// sqrt_sum_fsm: sums isqrt(arg[i]) over N_ARGS operands using N_ISQRT external isqrt lanes in batches.
// Optional SQRT_SUM_FSM_PERF_EN adds a saturating accept-to-result cycle counter on perf_cycles.
module sqrt_sum_fsm #(
    parameter int N_ARGS  = 3,
    parameter int N_ISQRT = 2,
    parameter int W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arg_vld,
    output logic                   arg_rdy,
    input  logic [N_ARGS*W-1:0]    args,
    output logic                   res_vld,
    input  logic                   res_rdy,
    output logic [W-1:0]           res,
    output logic [N_ISQRT-1:0]     isqrt_x_vld,
    output logic [N_ISQRT*W-1:0]   isqrt_x,
    input  logic [N_ISQRT-1:0]     isqrt_y_vld,
    input  logic [N_ISQRT*W/2-1:0] isqrt_y
`ifdef SQRT_SUM_FSM_PERF_EN
    ,
    output logic [15:0]            perf_cycles
`endif
);
    localparam int H     = W / 2;
    localparam int SUM_W = H + $clog2(N_ARGS);
    localparam int B     = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
    localparam int BW    = (B > 1) ? $clog2(B) : 1;
    localparam int LANES = B * N_ISQRT;

    generate
        if (W % 2 != 0 || SUM_W > W || N_ISQRT > N_ARGS || N_ISQRT < 1) begin : g_bad_params
            $error("sqrt_sum_fsm: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [N_ARGS*W-1:0]  args_q, args_d;
    logic [SUM_W-1:0]     acc_q, acc_d, add;
    logic [BW-1:0]        batch_q, batch_d, nb;
    logic [N_ISQRT-1:0]   pend_q, pend_d, hit, xv_q, xv_d, xv_nxt;
    logic [N_ISQRT*W-1:0] x_q, x_d, x_nxt;
    logic                 rdy_q, rdy_d, rv_q, rv_d;
    logic [W-1:0]         res_q, res_d;
    logic [LANES*W-1:0]   src_pad;
    logic [LANES-1:0]     mask_pad;

    // Zero padding past N_ARGS makes inactive lanes of the last batch read 0 / not valid.
    always_comb begin
        src_pad = '0;
        src_pad[N_ARGS*W-1:0] = (state_q == IDLE) ? args : args_q;
        mask_pad = '0;
        mask_pad[N_ARGS-1:0] = '1;
        nb = (state_q == IDLE || batch_q == BW'(B - 1)) ? '0 : batch_q + 1'b1;
        xv_nxt = mask_pad[int'(nb)*N_ISQRT +: N_ISQRT];
        x_nxt = src_pad[int'(nb)*N_ISQRT*W +: N_ISQRT*W];
        hit = isqrt_y_vld & pend_q;
        add = '0;
        for (int j = 0; j < N_ISQRT; j++)
            add = add + (hit[j] ? SUM_W'(isqrt_y[j*H +: H]) : '0);
        state_d = state_q;
        args_d  = args_q;
        acc_d   = acc_q;
        batch_d = batch_q;
        pend_d  = pend_q;
        xv_d    = '0;
        x_d     = '0;
        rdy_d   = rdy_q;
        rv_d    = rv_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (arg_vld) begin
                state_d = ISSUE;
                args_d  = args;
                acc_d   = '0;
                batch_d = '0;
                xv_d    = xv_nxt;
                x_d     = x_nxt;
                rdy_d   = 1'b0;
            end
            ISSUE: begin
                pend_d  = xv_q;
                state_d = WAIT;
            end
            WAIT: begin
                acc_d  = acc_q + add;
                pend_d = pend_q & ~hit;
                if (pend_d == '0) begin
                    if (batch_q == BW'(B - 1)) begin
                        state_d = DONE;
                        rv_d    = 1'b1;
                        res_d   = W'(acc_d);
                    end else begin
                        state_d = ISSUE;
                        batch_d = nb;
                        xv_d    = xv_nxt;
                        x_d     = x_nxt;
                    end
                end
            end
            DONE: if (res_rdy) begin
                state_d = IDLE;
                rv_d    = 1'b0;
                res_d   = '0;
                rdy_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SQRT_SUM_FSM_PERF_EN
    logic [15:0] cnt_q, cnt_d, cnt_inc, perf_q, perf_d;
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign cnt_d = (state_q == IDLE) ? (arg_vld ? 16'd1 : 16'd0) : (state_q == DONE) ? cnt_q : cnt_inc;
    assign perf_d = (state_q == WAIT && state_d == DONE) ? cnt_inc : perf_q;
    assign perf_cycles = perf_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            args_q  <= '0;
            acc_q   <= '0;
            batch_q <= '0;
            pend_q  <= '0;
            xv_q    <= '0;
            x_q     <= '0;
            rdy_q   <= 1'b1;
            rv_q    <= 1'b0;
            res_q   <= '0;
`ifdef SQRT_SUM_FSM_PERF_EN
            cnt_q   <= '0;
            perf_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            args_q  <= args_d;
            acc_q   <= acc_d;
            batch_q <= batch_d;
            pend_q  <= pend_d;
            xv_q    <= xv_d;
            x_q     <= x_d;
            rdy_q   <= rdy_d;
            rv_q    <= rv_d;
            res_q   <= res_d;
`ifdef SQRT_SUM_FSM_PERF_EN
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
`endif
        end
    end

    assign arg_rdy     = rdy_q;
    assign res_vld     = rv_q;
    assign res         = res_q;
    assign isqrt_x_vld = xv_q;
    assign isqrt_x     = x_q;
endmodule

// File: tb/tb_sqrt_sum_fsm.sv
// tb_sqrt_sum_fsm: directed vectors against sqrt_sum_fsm with a per-lane latency isqrt model.
module tb_sqrt_sum_fsm;
    logic        clk = 1'b0;
    logic        rst, arg_vld, res_rdy, arg_rdy, res_vld;
    logic [95:0] args;
    logic [31:0] res;
    logic [1:0]  x_vld, y_vld, y_vld_m, inj_vld;
    logic [63:0] x;
    logic [31:0] y, y_m, inj_y;
    logic        arg5_vld, arg5_rdy, res5_vld;
    logic [159:0] args5;
    logic [31:0] res5;
    logic [1:0]  x5_vld, y5_vld, p5_vld;
    logic [63:0] x5;
    logic [31:0] y5, p5_y;
`ifdef SQRT_SUM_FSM_PERF_EN
    logic [15:0] perf, perf5;
`endif
    int n_vec = 0, n_bad = 0;
    int lat[2];
    int cnt[2];
    logic [15:0] val[2];
    logic [1:0]  mask_log[$];
    logic [63:0] x_log[$];

    typedef struct {
        logic [31:0] a0, a1, a2;
        int          l0, l1;
        logic [31:0] er;
        int          el;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    assign y_vld = y_vld_m | inj_vld;
    assign y = (inj_vld != 2'b00) ? inj_y : y_m;

    sqrt_sum_fsm dut (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .args(args),
        .res_vld(res_vld), .res_rdy(res_rdy), .res(res),
        .isqrt_x_vld(x_vld), .isqrt_x(x), .isqrt_y_vld(y_vld), .isqrt_y(y)
`ifdef SQRT_SUM_FSM_PERF_EN
        , .perf_cycles(perf)
`endif
    );

    sqrt_sum_fsm #(.N_ARGS(5), .N_ISQRT(2), .W(32)) dut5 (
        .clk(clk), .rst(rst), .arg_vld(arg5_vld), .arg_rdy(arg5_rdy), .args(args5),
        .res_vld(res5_vld), .res_rdy(1'b1), .res(res5),
        .isqrt_x_vld(x5_vld), .isqrt_x(x5), .isqrt_y_vld(y5_vld), .isqrt_y(y5)
`ifdef SQRT_SUM_FSM_PERF_EN
        , .perf_cycles(perf5)
`endif
    );

    function automatic logic [15:0] isqrt(input logic [31:0] v);
        logic [15:0] r, t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if ({16'd0, t} * {16'd0, t} <= v) r = t;
        end
        return r;
    endfunction

    // Lane j answers lat[j] cycles after seeing its x_vld.
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            y_vld_m[j] = 1'b0;
            if (cnt[j] > 0) begin
                cnt[j]--;
                if (cnt[j] == 0) begin
                    y_vld_m[j] = 1'b1;
                    y_m[j*16 +: 16] = val[j];
                end
            end
            if (x_vld[j]) begin
                cnt[j] = lat[j];
                val[j] = isqrt(x[j*32 +: 32]);
            end
        end
        if (x_vld != 2'b00) begin
            mask_log.push_back(x_vld);
            x_log.push_back(x);
        end
    end

    always @(negedge clk) begin
        y5_vld = p5_vld;
        y5 = p5_y;
        p5_vld = x5_vld;
        for (int j = 0; j < 2; j++) p5_y[j*16 +: 16] = isqrt(x5[j*32 +: 32]);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [95:0] a, output logic [31:0] r, output int n);
        int k;
        k = 0;
        while (!arg_rdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        args = a;
        arg_vld = 1'b1;
        @(negedge clk);
        arg_vld = 1'b0;
        n = 1;
        while (!res_vld && n < 200) begin
            @(negedge clk);
            n++;
        end
        r = res;
    endtask

    initial begin
        logic [31:0] r;
        int n;
        tbl[0] = '{32'd9, 32'd16, 32'd25, 1, 1, 32'd12, 5};
        tbl[1] = '{32'd0, 32'd0, 32'd0, 1, 1, 32'd0, 5};
        tbl[2] = '{32'd9, 32'd16, 32'd25, 1, 4, 32'd12, 8};
        tbl[3] = '{32'd9, 32'd16, 32'd25, 4, 1, 32'd12, 11};
        tbl[4] = '{32'd9, 32'd16, 32'd25, 2, 2, 32'd12, 7};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'd196605, 5};
        tbl[6] = '{32'd1, 32'd2, 32'd3, 1, 1, 32'd3, 5};
        tbl[7] = '{32'd100, 32'd99, 32'd1000000, 3, 1, 32'd1019, 9};
        rst = 1'b1; arg_vld = 1'b0; args = '0; res_rdy = 1'b1;
        inj_vld = '0; inj_y = {16'h0100, 16'h0200};
        arg5_vld = 1'b0; args5 = '0;
        lat[0] = 1; lat[1] = 1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset arg_rdy", arg_rdy, 1);
        chk("reset res_vld", res_vld, 0);
        chk("reset res", res, 0);
        chk("reset x_vld", x_vld, 0);
        chk("reset x", x, 0);
        rst = 1'b1;
        @(negedge clk);
        inj_vld = 2'b11;
        @(negedge clk);
        inj_vld = 2'b00;
        chk("idle inject arg_rdy", arg_rdy, 1);
        chk("idle inject x_vld", x_vld, 0);

        for (int i = 0; i < 8; i++) begin
            lat[0] = tbl[i].l0;
            lat[1] = tbl[i].l1;
            mask_log.delete();
            x_log.delete();
            run_op({tbl[i].a2, tbl[i].a1, tbl[i].a0}, r, n);
            chk($sformatf("vec%0d res", i), r, tbl[i].er);
            chk($sformatf("vec%0d latency", i), n, tbl[i].el);
            @(negedge clk);
            chk($sformatf("vec%0d res_vld drop", i), res_vld, 0);
            chk($sformatf("vec%0d arg_rdy rise", i), arg_rdy, 1);
            if (i == 0) begin
                chk("vec0 issue count", mask_log.size(), 2);
                if (mask_log.size() >= 2) begin
                    chk("vec0 batch0 mask", mask_log[0], 2'b11);
                    chk("vec0 batch1 mask", mask_log[1], 2'b01);
                    chk("vec0 batch0 lane1 x", x_log[0][63:32], 16);
                    chk("vec0 batch1 lane0 x", x_log[1][31:0], 25);
                    chk("vec0 batch1 lane1 x", x_log[1][63:32], 0);
                end
`ifdef SQRT_SUM_FSM_PERF_EN
                chk("perf_cycles", perf, 5);
`endif
            end
        end

        res_rdy = 1'b0;
        lat[0] = 1; lat[1] = 1;
        run_op({32'd25, 32'd16, 32'd9}, r, n);
        chk("bp latency", n, 5);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp%0d res_vld", k), res_vld, 1);
            chk($sformatf("bp%0d res", k), res, 12);
            chk($sformatf("bp%0d arg_rdy", k), arg_rdy, 0);
            if (k == 3) begin
                args = {32'd4, 32'd4, 32'd4};
                arg_vld = 1'b1;
            end
            if (k == 4) arg_vld = 1'b0;
            inj_vld = (k == 5) ? 2'b11 : 2'b00;
            @(negedge clk);
        end
        inj_vld = 2'b00;
        res_rdy = 1'b1;
        @(negedge clk);
        chk("bp release res_vld", res_vld, 0);
        chk("bp release arg_rdy", arg_rdy, 1);
        @(negedge clk);
        chk("bp no spurious start", x_vld, 0);
        chk("bp still idle", arg_rdy, 1);

        lat[0] = 1; lat[1] = 6;
        args = {32'd25, 32'd16, 32'd9};
        arg_vld = 1'b1;
        @(negedge clk);
        arg_vld = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid-wait busy", arg_rdy, 0);
        rst = 1'b0;
        #1;
        chk("async rst arg_rdy", arg_rdy, 1);
        chk("async rst res_vld", res_vld, 0);
        chk("async rst res", res, 0);
        chk("async rst x_vld", x_vld, 0);
        chk("async rst x", x, 0);
        @(negedge clk);
        rst = 1'b1;
        lat[1] = 1;
        repeat (6) @(negedge clk);
        chk("post rst arg_rdy", arg_rdy, 1);
        chk("post rst res_vld", res_vld, 0);
        run_op({32'd4, 32'd4, 32'd4}, r, n);
        chk("post rst res", r, 6);
        chk("post rst latency", n, 5);
        @(negedge clk);

        args5 = {5{32'hFFFF_FFFF}};
        chk("n5 arg_rdy", arg5_rdy, 1);
        arg5_vld = 1'b1;
        @(negedge clk);
        arg5_vld = 1'b0;
        n = 1;
        while (!res5_vld && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("n5 res", res5, 327675);
        chk("n5 latency", n, 7);
        @(negedge clk);
        chk("n5 res_vld drop", res5_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/sqrt_sum_fsm.md
# sqrt_sum_fsm

Parametrised FSM that computes res = isqrt(arg[0]) + isqrt(arg[1]) + … + isqrt(arg[N_ARGS-1]) using N_ISQRT external isqrt instances in parallel. It is the generalised successor of the fixed three-argument, two-instance formula FSMs. It adds:
- arbitrary argument count, issued in batches;
- per-lane result collection;
- input backpressure;
- a held-until-accepted output handshake.

It sits between an argument producer and a bank of isqrt modules, and drives the modules' input ports and consumes their result ports.

## Interface
Parameters:
- N_ARGS, 3, number of operands summed (>= 1)
- N_ISQRT, 2, number of isqrt lanes used in parallel (1 <= N_ISQRT <= N_ARGS)
- W, 32, operand width; isqrt result width is W/2 (W even)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- arg_vld  in  1  argument vector valid
- arg_rdy  out  1  block can accept arguments
- args  in  N_ARGS*W  packed operands, arg[i] = args[i*W +: W]
- res_vld  out  1  result valid, held until accepted
- res_rdy  in  1  consumer accepts result
- res  out  W  zero-extended sum
- isqrt_x_vld  out  N_ISQRT  per-lane request strobe
- isqrt_x  out  N_ISQRT*W  per-lane operand
- isqrt_y_vld  in  N_ISQRT  per-lane result strobe
- isqrt_y  in  N_ISQRT*W/2  per-lane result

## Operation
- B = ceil(N_ARGS/N_ISQRT) batches. Batch k uses arg[k*N_ISQRT + j] on lane j.
- Lanes whose index is >= N_ARGS in the last batch are inactive: their x_vld is 0 and their x is 0.
- States:
  - IDLE: arg_rdy = 1. On arg_vld, register all args, clear acc, set batch = 0 and go to ISSUE.
  - ISSUE: one cycle. Assert isqrt_x_vld for the active lanes of the current batch, with isqrt_x taken from the registered args. Set the pending mask to the active lanes, then go to WAIT.
  - WAIT: any lane with y_vld and its pending bit set adds its isqrt_y to acc and clears its pending bit. Several lanes may arrive in the same cycle; all are summed that cycle.
    - When the pending mask becomes empty (including that cycle's arrivals) and batch < B-1: increment batch, go to ISSUE.
    - When the pending mask becomes empty and batch = B-1: go to DONE.
  - DONE: res_vld = 1 and res = acc zero-extended. Stay until res_rdy = 1, then go to IDLE.
- A y_vld on a lane that is not pending is ignored, in every state. Results arriving in IDLE after a reset are therefore discarded.
- The isqrt modules need only a one-cycle x_vld pulse. Results may return on different lanes in different cycles and in any order.
- Arithmetic: acc width SUM_W = W/2 + $clog2(N_ARGS). Elaboration fails if SUM_W > W, if W is odd, or if N_ISQRT > N_ARGS. No overflow is possible.
- res = 0 whenever res_vld = 0, so the output is never X.
- arg_vld while arg_rdy = 0 is ignored; the producer holds it.

## Timing
- Reset values (rst = 0, asynchronous): state IDLE, arg_rdy 1, res_vld 0, res 0, isqrt_x_vld 0, isqrt_x 0, acc 0, pending 0.
- Reset mid-operation aborts immediately. After release the block is in IDLE.
- isqrt_x_vld and isqrt_x are Moore outputs (registered state plus registered args) and depend only on the ISSUE state.
- Latency: let the isqrt latency be L, where y_vld is high L cycles after the x_vld cycle. res_vld then rises B*(L+1)+1 cycles after the arg accept cycle. Defaults with L = 1: 5 cycles.
- res_vld and res are stable while res_rdy = 0. The result transfers in the first cycle with res_vld && res_rdy, and arg_rdy rises the next cycle.
- Throughput: one operation per B*(L+1)+2 cycles when res_rdy is tied to 1.

## Configuration
- SQRT_SUM_FSM_PERF_EN defined: adds output port perf_cycles (16 bits, reset 0).
  - Counts cycles from the accept cycle (inclusive) to the first res_vld cycle (exclusive).
  - Updated on entry to DONE and saturates at 16'hFFFF.
- SQRT_SUM_FSM_PERF_EN undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Defaults, args = {9, 16, 25}, isqrt model L = 1, res_rdy = 1 -> res_vld for one cycle, 5 cycles after accept, with res = 12. Two batches: lanes 0 and 1 are active, then lane 0 only. Lane 1 x_vld = 0 in batch 1.
- N_ARGS = 5, N_ISQRT = 2, all args = 32'hFFFF_FFFF -> res = 5*65535 = 327675, 3 batches.
- Lane 1 returns 3 cycles after lane 0, then the two return in swapped order, then in the same cycle -> same sum in all cases. Extra y_vld pulses injected during IDLE and DONE are ignored.
- res_rdy held at 0 for 10 cycles in DONE -> res_vld and res are stable, arg_rdy = 0, and an arg_vld pulse is ignored. After res_rdy = 1, arg_rdy = 1 the next cycle.
- rst pulsed low in WAIT with a lane outstanding -> all outputs go to their reset values asynchronously. The late y_vld after release is ignored. The next op {4, 4, 4} gives res = 6.
- With SQRT_SUM_FSM_PERF_EN defined and the defaults above -> perf_cycles = 5.
